// File: rtl/rom_arbiter.sv
// Two-master arbiter in front of the combinational instruction ROM (M0 = fetch, M1 = debug/loader).
// Default: fixed M0 priority with a MAX_WAIT starvation escape for M1; define RR_ARB_EN for round-robin ties.
module rom_arbiter #(
  parameter int MAX_WAIT = 4,
  parameter int CNT_W    = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        m0_req,
  input  logic [31:0] m0_addr,
  output logic        m0_gnt,
  output logic        m0_rvalid,
  output logic [31:0] m0_rdata,
  input  logic        m1_req,
  input  logic [31:0] m1_addr,
  output logic        m1_gnt,
  output logic        m1_rvalid,
  output logic [31:0] m1_rdata,
  output logic        rom_ce,
  output logic [31:0] rom_addr,
  input  logic [31:0] rom_inst
);

  // Whether M1 takes a cycle in which both masters are requesting.
  logic m1_tie_win;

`ifdef RR_ARB_EN
  localparam logic [0:0] GNT_M0 = 1'b0;
  localparam logic [0:0] GNT_M1 = 1'b1;

  logic [0:0] last_gnt;

  assign m1_tie_win = (last_gnt == GNT_M0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)        last_gnt <= GNT_M1;
    else if (m0_gnt) last_gnt <= GNT_M0;
    else if (m1_gnt) last_gnt <= GNT_M1;
  end
`else
  logic [CNT_W-1:0] wait_cnt;

  assign m1_tie_win = (wait_cnt == CNT_W'(MAX_WAIT));

  // Counts consecutive denied M1 cycles, saturating at MAX_WAIT.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) wait_cnt <= '0;
    else if (m1_req && !m1_gnt) begin
      if (!m1_tie_win) wait_cnt <= wait_cnt + CNT_W'(1);
    end else wait_cnt <= '0;
  end
`endif

  assign m1_gnt   = m1_req & (~m0_req | m1_tie_win);
  assign m0_gnt   = m0_req & ~m1_gnt;
  assign rom_ce   = m0_gnt | m1_gnt;
  assign rom_addr = m0_gnt ? m0_addr : (m1_gnt ? m1_addr : 32'h0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      m0_rvalid <= 1'b0;
      m1_rvalid <= 1'b0;
      m0_rdata  <= 32'h0;
      m1_rdata  <= 32'h0;
    end else begin
      m0_rvalid <= m0_gnt;
      m1_rvalid <= m1_gnt;
      if (m0_gnt) m0_rdata <= rom_inst;
      if (m1_gnt) m1_rdata <= rom_inst;
    end
  end

endmodule

// File: tb/tb_rom_arbiter.sv
// Directed bench for rom_arbiter with a small ROM model (mem[i] = 0x1000_0000 + i).
// Covers fixed-priority starvation escape by default, round-robin when RR_ARB_EN is defined.
module tb_rom_arbiter;
  logic        clk = 1'b0;
  logic        rst;
  logic        m0_req, m1_req;
  logic [31:0] m0_addr, m1_addr;
  logic        m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, rom_ce;
  logic [31:0] m0_rdata, m1_rdata, rom_addr, rom_inst;
  logic [31:0] mem [16];
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  assign rom_inst = mem[rom_addr[5:2]];

  rom_arbiter #(.MAX_WAIT(4), .CNT_W(3)) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_addr(m0_addr), .m0_gnt(m0_gnt),
    .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_addr(m1_addr), .m1_gnt(m1_gnt),
    .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .rom_ce(rom_ce), .rom_addr(rom_addr), .rom_inst(rom_inst)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 32'h1000_0000 + 32'(i);
    rst = 1'b0; m0_req = 1'b0; m1_req = 1'b0; m0_addr = '0; m1_addr = '0;

    // 1: reset held, requests toggled
    #2;
    chk("rst_m0_rvalid", 32'(m0_rvalid), 0);
    chk("rst_m1_rvalid", 32'(m1_rvalid), 0);
    chk("rst_m0_rdata", m0_rdata, 0);
    chk("rst_m1_rdata", m1_rdata, 0);
    chk("rst_rom_ce", 32'(rom_ce), 0);
    chk("rst_rom_addr", rom_addr, 0);
    m0_req = 1'b1; m1_req = 1'b1; m0_addr = 32'h4; m1_addr = 32'h8;
    tick;
    chk("rst_tog_m0_rvalid", 32'(m0_rvalid), 0);
    chk("rst_tog_m1_rvalid", 32'(m1_rvalid), 0);
    chk("rst_tog_m0_rdata", m0_rdata, 0);
    m0_req = 1'b0; m1_req = 1'b0;
    tick;
    chk("rst_idle_rom_ce", 32'(rom_ce), 0);
    rst = 1'b1;
    tick;
    chk("post_rst_m0_rvalid", 32'(m0_rvalid), 0);
    chk("post_rst_rom_ce", 32'(rom_ce), 0);

    // 2: M0 alone, three sequential fetches
    m0_req = 1'b1; m0_addr = 32'h0; #1;
    chk("m0a_gnt", 32'(m0_gnt), 1);
    chk("m0a_m1_gnt", 32'(m1_gnt), 0);
    chk("m0a_rom_ce", 32'(rom_ce), 1);
    chk("m0a_rom_addr", rom_addr, 32'h0);
    tick;
    chk("m0a_rvalid", 32'(m0_rvalid), 1);
    chk("m0a_rdata", m0_rdata, 32'h1000_0000);
    m0_addr = 32'h4; #1;
    chk("m0b_rom_addr", rom_addr, 32'h4);
    tick;
    chk("m0b_rvalid", 32'(m0_rvalid), 1);
    chk("m0b_rdata", m0_rdata, 32'h1000_0001);
    m0_addr = 32'h8;
    tick;
    chk("m0c_rvalid", 32'(m0_rvalid), 1);
    chk("m0c_rdata", m0_rdata, 32'h1000_0002);
    chk("m0c_m1_rvalid", 32'(m1_rvalid), 0);
    m0_req = 1'b0;

    // 6: three idle cycles
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("idle_rom_ce", 32'(rom_ce), 0);
      chk("idle_rom_addr", rom_addr, 0);
      tick;
      chk("idle_m0_rvalid", 32'(m0_rvalid), 0);
      chk("idle_m1_rvalid", 32'(m1_rvalid), 0);
      chk("idle_m0_rdata_hold", m0_rdata, 32'h1000_0002);
    end

    // M1 alone once; also leaves last_gnt=M1 so M0 wins the next tie
    m1_req = 1'b1; m1_addr = 32'h14; #1;
    chk("m1_solo_gnt", 32'(m1_gnt), 1);
    chk("m1_solo_rom_addr", rom_addr, 32'h14);
    tick;
    chk("m1_solo_rvalid", 32'(m1_rvalid), 1);
    chk("m1_solo_rdata", m1_rdata, 32'h1000_0005);
    chk("m1_solo_m0_rvalid", 32'(m0_rvalid), 0);
    m1_req = 1'b0;
    tick;

    // Both requesting: M0 at 0x20 (mem[8]), M1 at 0x14 (mem[5])
    m0_req = 1'b1; m1_req = 1'b1; m0_addr = 32'h20; m1_addr = 32'h14;
    for (int i = 0; i < 6; i++) begin
      logic exp_m1;
`ifdef RR_ARB_EN
      exp_m1 = (i % 2) == 1;
`else
      exp_m1 = (i == 4);
`endif
      #1;
      chk("tie_m1_gnt", 32'(m1_gnt), 32'(exp_m1));
      chk("tie_m0_gnt", 32'(m0_gnt), 32'(!exp_m1));
      chk("tie_rom_addr", rom_addr, exp_m1 ? 32'h14 : 32'h20);
      tick;
      chk("tie_m1_rvalid", 32'(m1_rvalid), 32'(exp_m1));
      chk("tie_m0_rvalid", 32'(m0_rvalid), 32'(!exp_m1));
      if (exp_m1) chk("tie_m1_rdata", m1_rdata, 32'h1000_0005);
      else        chk("tie_m0_rdata", m0_rdata, 32'h1000_0008);
    end
    m0_req = 1'b0; m1_req = 1'b0;
    tick;
    chk("tie_end_rvalid", 32'({m0_rvalid, m1_rvalid}), 0);

    // 5: reset right after an M1 grant
    m1_req = 1'b1; m1_addr = 32'h10;
    tick;
    chk("rstmid_m1_rvalid_pre", 32'(m1_rvalid), 1);
    chk("rstmid_m1_rdata_pre", m1_rdata, 32'h1000_0004);
    m1_req = 1'b0; rst = 1'b0; #1;
    chk("rstmid_m1_rvalid", 32'(m1_rvalid), 0);
    chk("rstmid_m1_rdata", m1_rdata, 0);
    chk("rstmid_m0_rdata", m0_rdata, 0);
    tick;
    rst = 1'b1;
    tick;
    chk("rstmid_release_m1_rvalid", 32'(m1_rvalid), 0);
    chk("rstmid_release_rom_ce", 32'(rom_ce), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
